snake_vga_fetch: RTL and testbench

- Display-side fetch engine on the VGA port of data memory (address_dmem_fromVGA / data_fromVGA / wren_fromVGA / q_dmem_toVGA).
- Once per frame, on a vblank trigger, reads the snake header and segment words that the game program writes to dmem.
- Holds them in a shadow buffer and commits them atomically to a flat segment bus for the pixel renderer, so the display never shows a half-updated snake.

---
 rtl/snake_pkg.sv | 35 +++
 rtl/snake_vga_fetch_seg_buffer.sv | 31 +++
 rtl/snake_vga_fetch.sv | 162 ++++++++++++++++
 tb/tb_snake_vga_fetch.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Shared types and constants for the snake display fetch engine.
package snake_pkg;

   localparam int unsigned ADDR_W  = 12;
   localparam int unsigned SEG_W   = 32;
   localparam int unsigned LEN_W   = 8;
   localparam int unsigned COORD_W = 16;

   // Segment word layout: {y, x}
   localparam int unsigned SEG_X_LSB = 0;
   localparam int unsigned SEG_Y_LSB = 16;

   localparam logic [ADDR_W-1:0] DEF_BASE_ADDR    = 12'h800;
   localparam logic [ADDR_W-1:0] DEF_MAILBOX_ADDR = 12'h7FF;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_DIRW   = 3'd1,
      ST_HDR    = 3'd2,
      ST_HLAT   = 3'd3,
      ST_FETCH  = 3'd4,
      ST_DRAIN  = 3'd5,
      ST_COMMIT = 3'd6
   } state_t;

   function automatic logic [SEG_W-1:0] seg_word(input logic [COORD_W-1:0] y,
                                                 input logic [COORD_W-1:0] x);
      logic [SEG_W-1:0] w;
      w = '0;
      w[SEG_Y_LSB +: COORD_W] = y;
      w[SEG_X_LSB +: COORD_W] = x;
      return w;
   endfunction

endpackage

// File: rtl/snake_vga_fetch_seg_buffer.sv
// Shadow segment store plus the committed output register; commit masks entries at or beyond len.
module snake_seg_buffer
   import snake_pkg::*;
#(
   parameter int unsigned NUM_SEG = 10
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     wr_en,
   input  logic [LEN_W-1:0]         wr_idx,
   input  logic [SEG_W-1:0]         wr_data,
   input  logic                     commit,
   input  logic [LEN_W-1:0]         len,
   output logic [NUM_SEG*SEG_W-1:0] data
);

   logic [NUM_SEG-1:0][SEG_W-1:0] shadow;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         shadow <= '0;
         data   <= '0;
      end else begin
         for (int unsigned i = 0; i < NUM_SEG; i++) begin
            if (wr_en && (wr_idx == LEN_W'(i))) shadow[i] <= wr_data;
            if (commit) data[i*SEG_W +: SEG_W] <= (LEN_W'(i) < len) ? shadow[i] : '0;
         end
      end
   end

endmodule

// File: rtl/snake_vga_fetch.sv
// Per-frame snake fetch from dmem into a shadow buffer with atomic commit.
// Optional SNAKE_DIR_MAILBOX_EN writes the latched direction to a mailbox word before fetching.
module snake_vga_fetch
   import snake_pkg::*;
#(
   parameter int unsigned        NUM_SEG      = 10,
   parameter logic [ADDR_W-1:0]  BASE_ADDR    = DEF_BASE_ADDR
`ifdef SNAKE_DIR_MAILBOX_EN
   ,parameter logic [ADDR_W-1:0] MAILBOX_ADDR = DEF_MAILBOX_ADDR
`endif
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     vblank_start,
   output logic [ADDR_W-1:0]        address_dmem_fromVGA,
   output logic [SEG_W-1:0]         data_fromVGA,
   output logic                     wren_fromVGA,
   input  logic [SEG_W-1:0]         q_dmem_toVGA,
   output logic [NUM_SEG*SEG_W-1:0] snake_data,
   output logic [LEN_W-1:0]         snake_len,
   output logic                     frame_ready,
   output logic                     busy,
   output logic                     overrun
`ifdef SNAKE_DIR_MAILBOX_EN
   ,input logic [1:0]               dir
   ,input logic                     dir_valid
`endif
);

   state_t           state;
   logic [LEN_W-1:0] k;
   logic [LEN_W-1:0] len_r;
   logic [LEN_W-1:0] hdr_n;
   logic             wr_en;
   logic [LEN_W-1:0] wr_idx;
   logic             commit;

   assign hdr_n   = (q_dmem_toVGA[LEN_W-1:0] > LEN_W'(NUM_SEG)) ? LEN_W'(NUM_SEG)
                                                                 : q_dmem_toVGA[LEN_W-1:0];
   assign overrun = vblank_start & (state != ST_IDLE);

   // Read data lags its address by one cycle, so FETCH k stores word k-1.
   always_comb begin
      wr_en  = 1'b0;
      wr_idx = k - LEN_W'(1);
      commit = 1'b0;
      case (state)
         ST_FETCH:  wr_en = (k != '0);
         ST_DRAIN:  begin
            wr_en  = 1'b1;
            wr_idx = len_r - LEN_W'(1);
         end
         ST_COMMIT: commit = 1'b1;
         default:   ;
      endcase
   end

`ifdef SNAKE_DIR_MAILBOX_EN
   logic [1:0] dir_r;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset)         dir_r <= 2'b00;
      else if (dir_valid) dir_r <= dir;
   end
`else
   assign wren_fromVGA = 1'b0;
   assign data_fromVGA = '0;
`endif

   // Outputs are loaded with the value belonging to the state being entered.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state                <= ST_IDLE;
         k                    <= '0;
         len_r                <= '0;
         address_dmem_fromVGA <= '0;
         snake_len            <= '0;
         frame_ready          <= 1'b0;
         busy                 <= 1'b0;
`ifdef SNAKE_DIR_MAILBOX_EN
         wren_fromVGA         <= 1'b0;
         data_fromVGA         <= '0;
`endif
      end else begin
         frame_ready <= 1'b0;
`ifdef SNAKE_DIR_MAILBOX_EN
         wren_fromVGA <= 1'b0;
         data_fromVGA <= '0;
`endif
         case (state)
            ST_IDLE: begin
               address_dmem_fromVGA <= BASE_ADDR;
               if (vblank_start) begin
                  busy <= 1'b1;
`ifdef SNAKE_DIR_MAILBOX_EN
                  state                <= ST_DIRW;
                  address_dmem_fromVGA <= MAILBOX_ADDR;
                  wren_fromVGA         <= 1'b1;
                  data_fromVGA         <= {30'b0, dir_r};
`else
                  state <= ST_HDR;
`endif
               end
            end
            ST_DIRW: begin
               state                <= ST_HDR;
               address_dmem_fromVGA <= BASE_ADDR;
            end
            ST_HDR: begin
               state                <= ST_HLAT;
               address_dmem_fromVGA <= BASE_ADDR;
            end
            ST_HLAT: begin
               len_r <= hdr_n;
               k     <= '0;
               if (hdr_n == '0) begin
                  state       <= ST_COMMIT;
                  frame_ready <= 1'b1;
               end else begin
                  state                <= ST_FETCH;
                  address_dmem_fromVGA <= BASE_ADDR + ADDR_W'(1);
               end
            end
            ST_FETCH: begin
               if (k == len_r - LEN_W'(1)) begin
                  state                <= ST_DRAIN;
                  address_dmem_fromVGA <= BASE_ADDR;
               end else begin
                  k                    <= k + LEN_W'(1);
                  address_dmem_fromVGA <= BASE_ADDR + ADDR_W'(2) + ADDR_W'(k);
               end
            end
            ST_DRAIN: begin
               state       <= ST_COMMIT;
               frame_ready <= 1'b1;
            end
            ST_COMMIT: begin
               state                <= ST_IDLE;
               busy                 <= 1'b0;
               snake_len            <= len_r;
               address_dmem_fromVGA <= BASE_ADDR;
            end
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   snake_seg_buffer #(.NUM_SEG(NUM_SEG)) u_buf (
      .clock   (clock),
      .reset   (reset),
      .wr_en   (wr_en),
      .wr_idx  (wr_idx),
      .wr_data (q_dmem_toVGA),
      .commit  (commit),
      .len     (len_r),
      .data    (snake_data)
   );

endmodule

// File: tb/tb_snake_vga_fetch.sv
// Scoreboard bench for snake_vga_fetch with a one-cycle-latency dmem model.
module tb_snake_vga_fetch;
   import snake_pkg::*;

   localparam int unsigned NS = 10;
   localparam int unsigned BW = NS * 32;
   localparam logic [11:0] BASE = 12'h800;
   localparam logic [11:0] MAIL = 12'h7FF;
`ifdef SNAKE_DIR_MAILBOX_EN
   localparam int DL = 1;
`else
   localparam int DL = 0;
`endif

   logic          clock;
   logic          reset;
   logic          vblank_start;
   logic [11:0]   address;
   logic [31:0]   data_w;
   logic          wren;
   logic [31:0]   q;
   logic [BW-1:0] snake_data;
   logic [7:0]    snake_len;
   logic          frame_ready;
   logic          busy;
   logic          overrun;
`ifdef SNAKE_DIR_MAILBOX_EN
   logic [1:0]    dir;
   logic          dir_valid;
`endif

   snake_vga_fetch dut (
      .clock                (clock),
      .reset                (reset),
      .vblank_start         (vblank_start),
      .address_dmem_fromVGA (address),
      .data_fromVGA         (data_w),
      .wren_fromVGA         (wren),
      .q_dmem_toVGA         (q),
      .snake_data           (snake_data),
      .snake_len            (snake_len),
      .frame_ready          (frame_ready),
      .busy                 (busy),
      .overrun              (overrun)
`ifdef SNAKE_DIR_MAILBOX_EN
      ,.dir                 (dir)
      ,.dir_valid           (dir_valid)
`endif
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   logic [31:0] mem [4096];
   always @(posedge clock) begin
      q <= mem[address];
      if (wren) mem[address] = data_w;
   end

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   typedef struct {
      int            cyc;
      logic [7:0]    len;
      logic [BW-1:0] data;
   } exp_t;

   exp_t sb[$];
   exp_t pend;
   bit   chk_next = 0;

   // Frame monitor: timing at the frame_ready cycle, committed contents one cycle later.
   always @(negedge clock) begin
      if (chk_next) begin
         chk("data", snake_data, pend.data);
         chk("len", BW'(snake_len), BW'(pend.len));
         chk_next = 0;
      end
      if (frame_ready) begin
         if (sb.size() == 0) chk("fr_spurious", BW'(frame_ready), BW'(0));
         else begin
            pend = sb.pop_front();
            chk("fr_cyc", BW'(cyc), BW'(pend.cyc));
            chk_next = 1;
         end
      end
   end

   int          nreads;
   logic [11:0] amin, amax;
   always @(negedge clock) begin
      if (busy && address != BASE && address != MAIL) begin
         nreads++;
         if (address < amin) amin = address;
         if (address > amax) amax = address;
      end
   end

   logic [1:0] exp_dir = 2'b00;

   task automatic wait_cyc(input int c);
      while (cyc < c) @(negedge clock);
   endtask

   task automatic pulse(output int t);
      @(negedge clock);
      vblank_start = 1'b1;
      t = cyc;
      #1 chk("ovr_idle", BW'(overrun), BW'(0));
      @(negedge clock);
      vblank_start = 1'b0;
   endtask

   task automatic expect_frame(input int t, input int n);
      exp_t e;
      e.cyc  = (n == 0) ? t + 3 + DL : t + 4 + n + DL;
      e.len  = 8'(n);
      e.data = '0;
      for (int i = 0; i < n; i++) e.data[i*32 +: 32] = mem[BASE + 12'(1 + i)];
      sb.push_back(e);
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 100 && (sb.size() != 0 || chk_next); i++) @(negedge clock);
      chk("drain", BW'(sb.size()), BW'(0));
   endtask

   task automatic frame(input int n, input string tag);
      int t;
      int lat;
      nreads = 0;
      amin   = 12'hFFF;
      amax   = 12'h000;
      pulse(t);
      expect_frame(t, n);
      lat = (n == 0) ? 3 + DL : 4 + n + DL;
`ifdef SNAKE_DIR_MAILBOX_EN
      chk({tag, "_wren"}, BW'(wren), BW'(1));
      chk({tag, "_maddr"}, BW'(address), BW'(MAIL));
      chk({tag, "_mdata"}, BW'(data_w), BW'({30'b0, exp_dir}));
`else
      chk({tag, "_wren"}, BW'(wren), BW'(0));
      chk({tag, "_wdata"}, BW'(data_w), BW'(0));
      chk({tag, "_haddr"}, BW'(address), BW'(BASE));
`endif
      for (int c = 1; c <= lat; c++) begin
         wait_cyc(t + c);
         chk({tag, "_busy"}, BW'(busy), BW'(1));
      end
      wait_cyc(t + lat + 1);
      chk({tag, "_idle"}, BW'(busy), BW'(0));
      wait_drain();
      chk({tag, "_nreads"}, BW'(nreads), BW'(n));
   endtask

   initial begin
      int t;
      reset        = 1'b0;
      vblank_start = 1'b0;
`ifdef SNAKE_DIR_MAILBOX_EN
      dir       = 2'b00;
      dir_valid = 1'b0;
`endif
      for (int i = 0; i < 4096; i++) mem[i] = '0;
      repeat (3) @(negedge clock);
      chk("rst_busy", BW'(busy), BW'(0));
      chk("rst_fr", BW'(frame_ready), BW'(0));
      chk("rst_len", BW'(snake_len), BW'(0));
      chk("rst_data", snake_data, '0);
      chk("rst_addr", BW'(address), BW'(0));
      chk("rst_wren", BW'(wren), BW'(0));
      reset = 1'b1;
      repeat (3) @(negedge clock);

      // Three segments
      mem[BASE]     = 32'd3;
      mem[BASE + 1] = seg_word(16'd5, 16'd4);
      mem[BASE + 2] = seg_word(16'd5, 16'd5);
      mem[BASE + 3] = seg_word(16'd5, 16'd6);
      mem[BASE + 4] = 32'hDEAD_BEEF;
      frame(3, "n3");

      // Empty snake clears the previous frame
      mem[BASE] = 32'd0;
      frame(0, "n0");

      // Oversized header clamps to NUM_SEG
      mem[BASE] = 32'h0000_FF2A;
      for (int i = 1; i <= 11; i++) mem[BASE + 12'(i)] = $urandom() | 32'h1;
      frame(10, "clamp");
      chk("clamp_amin", BW'(amin), BW'(12'h801));
      chk("clamp_amax", BW'(amax), BW'(12'h80A));

      // Retrigger during fetch and in COMMIT is ignored
      mem[BASE]     = 32'h1234_5603;
      mem[BASE + 1] = seg_word(16'd9, 16'd1);
      mem[BASE + 2] = seg_word(16'd9, 16'd2);
      mem[BASE + 3] = seg_word(16'd9, 16'd3);
      pulse(t);
      expect_frame(t, 3);
      wait_cyc(t + 4);
      vblank_start = 1'b1;
      #1 chk("ovr_fetch", BW'(overrun), BW'(1));
      chk("ovr_busy", BW'(busy), BW'(1));
      @(negedge clock);
      vblank_start = 1'b0;
      #1 chk("ovr_clear", BW'(overrun), BW'(0));
      wait_cyc(t + 7 + DL);
      vblank_start = 1'b1;
      #1 chk("ovr_commit", BW'(overrun), BW'(1));
      chk("ovr_fr", BW'(frame_ready), BW'(1));
      @(negedge clock);
      vblank_start = 1'b0;
      #1 chk("ovr_noretrig", BW'(busy), BW'(0));
      wait_cyc(t + 25);
      chk("ovr_idle_late", BW'(busy), BW'(0));
      wait_drain();

      // Reset mid-fetch discards everything
      mem[BASE]     = 32'd3;
      mem[BASE + 1] = seg_word(16'd7, 16'd7);
      pulse(t);
      wait_cyc(t + 5);
      reset = 1'b0;
      sb.delete();
      #1;
      chk("mrst_busy", BW'(busy), BW'(0));
      chk("mrst_addr", BW'(address), BW'(0));
      chk("mrst_data", snake_data, '0);
      chk("mrst_len", BW'(snake_len), BW'(0));
      chk("mrst_fr", BW'(frame_ready), BW'(0));
      repeat (2) @(negedge clock);
      reset = 1'b1;
      repeat (8) @(negedge clock);
      chk("mrst_hold_data", snake_data, '0);
      chk("mrst_hold_busy", BW'(busy), BW'(0));

`ifdef SNAKE_DIR_MAILBOX_EN
      @(negedge clock);
      dir       = 2'b10;
      dir_valid = 1'b1;
      @(negedge clock);
      dir       = 2'b01;
      dir_valid = 1'b0;
      exp_dir   = 2'b10;
`endif
      frame(3, "final");
`ifdef SNAKE_DIR_MAILBOX_EN
      chk("mailbox_mem", BW'(mem[MAIL]), BW'(32'h2));
`endif

      repeat (3) @(negedge clock);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
